// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access path.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam int unsigned MEM_WAIT_DEFAULT = 2;

  localparam logic MDR_SEL_BUS = 1'b0;
  localparam logic MDR_SEL_MEM = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; holds at zero rather than wrapping.
module mem_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: owns MAR/MDR and sequences fixed-latency
// SRAM reads and writes. All outputs are decoded from registered state only.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] mdr_in,
  output logic              mdr_sel,
  input  logic              mem_req,
  input  logic              mem_wr,
  output logic              mem_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              wr_q, wr_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  mem_wait_counter u_wait (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (cnt_load),
    .load_val_i (4'(WAIT_CYCLES - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    wr_d     = wr_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus[ADDR_W-1:0];
        if (ld_mdr) mdr_d = mdr_in;
        if (mem_req) begin
          state_d  = ACCESS;
          wr_d     = mem_wr;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        // Read data is captured on the edge that leaves ACCESS.
        if (cnt_zero) begin
          state_d = DONE;
          if (!wr_q) mdr_d = mdr_in;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      wr_q    <= wr_d;
    end
  end

  assign mem_ce    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && wr_q;
  assign mem_oe    = (state_q == ACCESS) && !wr_q;
  assign mdr_sel   = ((state_q == ACCESS) && !wr_q) ? MDR_SEL_MEM : MDR_SEL_BUS;
  assign busy      = (state_q == ACCESS) || (state_q == DONE);
  assign mem_done  = (state_q == DONE);
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule
